// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch buffer between unified memory and the decoder. It issues
// sequential word fetches whenever the core is not using the bus. It queues the
// returned words, tagged with their word PC, in a DEPTH-entry circular FIFO.
// The decoder reads them through a valid/ready handshake. A redirect flushes the
// queue, drops any in-flight fetch and restarts fetching at redirect_pc.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a response arriving while the queue is empty is presented to
//   the decoder in the same cycle. If the decoder takes it, it is never written.
//
// Parameters:
//   DEPTH       queue entries (power of two, >= 2)
//   RESET_PC    word address fetched first after reset
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus_busy     core owns memory this cycle; blocks fetch issue
//   fetch_req    a fetch is issued this cycle
//   mem_addr     byte address {fetch_pc, 2'b0}
//   mem_rdata    read data for the address issued the previous cycle
//   redirect     flush and restart at redirect_pc
//   redirect_pc  new word fetch PC
//   inst_valid   head entry presentable
//   inst_ready   decoder accepts head
//   inst         head instruction (zero when not valid)
//   inst_pc      head word PC (zero when not valid)
//   count        occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bus_busy,
    output logic                       fetch_req,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_rdata,
    input  logic                       redirect,
    input  logic [29:0]                redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [29:0]                inst_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [29:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [29:0]   inflight_pc_q, inflight_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   data_mem [DEPTH];
    logic [29:0]   pc_mem   [DEPTH];

    logic          issue;
    logic          resp;
    logic          empty;
    logic          bypass;
    logic          pop;
    logic          wr_en;
    logic          rd_en;
    logic [CW-1:0] reserved;

    // Slots already claimed: stored entries plus the one response still due.
    // Issue only when a slot is free, so a push can never overflow.
    assign reserved = count_q + CW'(inflight_q);
    assign issue    = !rst && !redirect && !bus_busy && (reserved < CW'(DEPTH));
    assign resp     = inflight_q && !redirect && !rst;
    assign empty    = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = empty && resp;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        inst_valid = !rst && !redirect && (!empty || bypass);
        inst       = '0;
        inst_pc    = '0;
        if (inst_valid) begin
            if (bypass) begin
                inst    = mem_rdata;
                inst_pc = inflight_pc_q;
            end else begin
                inst    = data_mem[rd_ptr_q];
                inst_pc = pc_mem[rd_ptr_q];
            end
        end
    end

    assign pop = inst_valid && inst_ready;

    // A bypassed word taken by the decoder never touches storage. When the
    // decoder does not take it, the word is stored like any other response.
    assign wr_en = resp && !(bypass && pop);
    assign rd_en = pop && !bypass;

    assign fetch_req = issue;
    assign mem_addr  = rst ? {RESET_PC, 2'b00} : {fetch_pc_q, 2'b00};
    assign count     = rst ? '0 : count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 30'd1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule
